// File: rtl/solve_sequencer_if.sv
// Run-control bundle between the solve sequencer, the puzzle loader,
// the solver array and the result transfer path.
interface solve_sequencer_if #(
   parameter int CYC_W = 16
);
   logic             load_done;
   logic             abort;
   logic             solver_start;
   logic             solver_done;
   logic             solver_fail;
   logic [6:0]       cells_solved;
   logic             busy;
   logic             result_valid;
   logic             result_ready;
   logic [1:0]       status;
   logic [CYC_W-1:0] cycles;

   // Sequencer side
   modport master (
      input  load_done, abort, solver_done, solver_fail, cells_solved, result_ready,
      output solver_start, busy, result_valid, status, cycles
   );

   // Environment side (loader, solver, consumer)
   modport slave (
      output load_done, abort, solver_done, solver_fail, cells_solved, result_ready,
      input  solver_start, busy, result_valid, status, cycles
   );
endinterface

// File: rtl/solve_sequencer.sv
// Solver run-control: issues a one-cycle start, watches the solver for
// solved / fail / stall / timeout and hands a status + cycle count to the
// consumer with a valid/ready handshake. All outputs come straight from flops.
module solve_sequencer #(
   parameter int CYC_W       = 16,
   parameter int STALL_LIMIT = 4,
   parameter int MAX_CYCLES  = 1000
) (
   input  logic              clk,
   input  logic              reset_L,
   solve_sequencer_if.master bus
);
   localparam int SC_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_START  = 2'd1,
      S_SOLVE  = 2'd2,
      S_REPORT = 2'd3
   } state_t;

   localparam logic [1:0] ST_NONE   = 2'b00;
   localparam logic [1:0] ST_SOLVED = 2'b01;
   localparam logic [1:0] ST_FAIL   = 2'b10;
   localparam logic [1:0] ST_STALL  = 2'b11;

   state_t           state_q, state_d;
   logic [CYC_W-1:0] cycles_q, cycles_d;
   logic [1:0]       status_q, status_d;
   logic [6:0]       last_solved_q, last_solved_d;
   logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic             solver_start_q, solver_start_d;
   logic             busy_q, busy_d;
   logic             result_valid_q, result_valid_d;

   logic [CYC_W-1:0] cycles_inc;
   logic             at_budget;
   logic             no_progress;
   logic             stall_hit;

   // Next-state, result and progress-tracking logic
   always_comb begin
      state_d       = state_q;
      cycles_d      = cycles_q;
      status_d      = status_q;
      last_solved_d = last_solved_q;
      stall_cnt_d   = stall_cnt_q;

      cycles_inc  = (cycles_q == '1) ? cycles_q : cycles_q + CYC_W'(1);
      // This cycle is the MAX_CYCLES-th one; wider compare avoids wrap.
      at_budget   = ({1'b0, cycles_q} + (CYC_W+1)'(1)) == (CYC_W+1)'(MAX_CYCLES);
      no_progress = (bus.cells_solved == last_solved_q);
      stall_hit   = no_progress && (stall_cnt_q == SC_W'(STALL_LIMIT - 1));

      case (state_q)
         S_IDLE: begin
            if (bus.load_done) begin
               // Clear the old result as the run is launched so START already shows 00/0.
               state_d       = S_START;
               cycles_d      = '0;
               status_d      = ST_NONE;
               last_solved_d = '0;
               stall_cnt_d   = '0;
            end
         end
         S_START: begin
            state_d       = S_SOLVE;
            cycles_d      = '0;
            status_d      = ST_NONE;
            last_solved_d = '0;
            stall_cnt_d   = '0;
         end
         S_SOLVE: begin
            cycles_d = cycles_inc;
            if (no_progress) begin
               stall_cnt_d = stall_cnt_q + SC_W'(1);
            end else begin
               last_solved_d = bus.cells_solved;
               stall_cnt_d   = '0;
            end
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (bus.solver_fail) begin
               state_d  = S_REPORT;
               status_d = ST_FAIL;
            end else if (bus.solver_done) begin
               state_d  = S_REPORT;
               status_d = ST_SOLVED;
            end else if (stall_hit || at_budget) begin
               state_d  = S_REPORT;
               status_d = ST_STALL;
            end
         end
         S_REPORT: begin
            if (result_valid_q && bus.result_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      solver_start_d = (state_d == S_START);
      busy_d         = (state_d == S_START) || (state_d == S_SOLVE);
      result_valid_d = (state_d == S_REPORT);
   end

   // State and registered output decodes; reset drops any run in progress
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q        <= S_IDLE;
         cycles_q       <= '0;
         status_q       <= ST_NONE;
         last_solved_q  <= '0;
         stall_cnt_q    <= '0;
         solver_start_q <= 1'b0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cycles_q       <= cycles_d;
         status_q       <= status_d;
         last_solved_q  <= last_solved_d;
         stall_cnt_q    <= stall_cnt_d;
         solver_start_q <= solver_start_d;
         busy_q         <= busy_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign bus.solver_start = solver_start_q;
   assign bus.busy         = busy_q;
   assign bus.result_valid = result_valid_q;
   assign bus.status       = status_q;
   assign bus.cycles       = cycles_q;
endmodule

// File: tb/tb_solve_sequencer.sv
// Bench for solve_sequencer: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a run-level model.
module tb_solve_sequencer;
   localparam int CYC_W       = 16;
   localparam int STALL_LIMIT = 4;
   localparam int MAX_CYCLES  = 8;

   localparam int P_IDLE   = 0;
   localparam int P_START  = 1;
   localparam int P_RUN    = 2;
   localparam int P_REPORT = 3;

   logic clk     = 1'b0;
   logic reset_L = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   // Model state
   int m_phase;
   int m_status;
   int m_cycles;
   int m_len;
   int hist[$];

   solve_sequencer_if #(.CYC_W(CYC_W)) bus ();

   solve_sequencer #(
      .CYC_W      (CYC_W),
      .STALL_LIMIT(STALL_LIMIT),
      .MAX_CYCLES (MAX_CYCLES)
   ) dut (
      .clk    (clk),
      .reset_L(reset_L),
      .bus    (bus.master)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Stalled when the last STALL_LIMIT samples all equal the value before them
   // (the value before the first sample of a run is 0).
   function automatic bit stalled();
      int n = hist.size();
      if (n - 1 < STALL_LIMIT) return 1'b0;
      for (int i = n - 1 - STALL_LIMIT; i < n; i++)
         if (hist[i] != hist[n-1]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_reset();
      m_phase  = P_IDLE;
      m_status = 0;
      m_cycles = 0;
      m_len    = 0;
      hist.delete();
   endtask

   task automatic m_step();
      case (m_phase)
         P_IDLE: begin
            if (bus.load_done) begin
               m_phase  = P_START;
               m_status = 0;
               m_cycles = 0;
            end
         end
         P_START: begin
            m_phase = P_RUN;
            m_len   = 0;
            hist.delete();
            hist.push_back(0);
         end
         P_RUN: begin
            m_len++;
            if (m_cycles < (2**CYC_W) - 1) m_cycles++;
            hist.push_back(int'(bus.cells_solved));
            if (bus.abort) m_phase = P_IDLE;
            else if (bus.solver_fail) begin m_phase = P_REPORT; m_status = 2; end
            else if (bus.solver_done) begin m_phase = P_REPORT; m_status = 1; end
            else if (stalled())       begin m_phase = P_REPORT; m_status = 3; end
            else if (m_len == MAX_CYCLES) begin m_phase = P_REPORT; m_status = 3; end
         end
         default: begin
            if (bus.result_ready) m_phase = P_IDLE;
         end
      endcase
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge reset_L);
         if (!reset_L) m_reset();
         else m_step();
      end
   end

   // Compare process: outputs against the model on every falling edge
   always @(negedge clk) begin
      chk("solver_start", int'(bus.solver_start), (m_phase == P_START) ? 1 : 0);
      chk("busy", int'(bus.busy), (m_phase == P_START || m_phase == P_RUN) ? 1 : 0);
      chk("result_valid", int'(bus.result_valid), (m_phase == P_REPORT) ? 1 : 0);
      chk("status", int'(bus.status), m_status);
      chk("cycles", int'(bus.cycles), m_cycles);
   end

   task automatic step();
      @(negedge clk);
   endtask

   // Pulse load_done; returns at the falling edge inside SOLVE cycle 1
   task automatic start_run();
      bus.load_done = 1'b1;
      step();
      bus.load_done = 1'b0;
      chk("start_pulse", int'(bus.solver_start), 1);
      chk("start_busy", int'(bus.busy), 1);
      chk("start_status", int'(bus.status), 0);
      step();
      chk("start_single", int'(bus.solver_start), 0);
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!bus.result_valid && n < budget) begin
         step();
         n++;
      end
      chk("valid_within_budget", int'(bus.result_valid), 1);
   endtask

   task automatic drain();
      bus.result_ready = 1'b1;
      step();
      bus.result_ready = 1'b0;
      chk("valid_low_after_xfer", int'(bus.result_valid), 0);
      chk("idle_after_xfer", int'(bus.busy), 0);
   endtask

   initial begin
      bus.load_done    = 1'b0;
      bus.abort        = 1'b0;
      bus.solver_done  = 1'b0;
      bus.solver_fail  = 1'b0;
      bus.cells_solved = 7'd0;
      bus.result_ready = 1'b0;
      repeat (3) step();
      reset_L = 1'b1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_valid", int'(bus.result_valid), 0);
      chk("rst_start", int'(bus.solver_start), 0);
      chk("rst_status", int'(bus.status), 0);
      chk("rst_cycles", int'(bus.cycles), 0);

      // Normal solve in 4 cycles, consumer back-pressure, then transfer
      start_run();
      bus.cells_solved = 7'd30; step();
      bus.cells_solved = 7'd45; step();
      bus.cells_solved = 7'd60; step();
      bus.cells_solved = 7'd81; bus.solver_done = 1'b1; step();
      bus.solver_done = 1'b0;
      chk("solved_valid", int'(bus.result_valid), 1);
      chk("solved_status", int'(bus.status), 1);
      chk("solved_cycles", int'(bus.cycles), 4);
      chk("model_solved_status", m_status, 1);
      repeat (10) begin
         step();
         chk("hold_valid", int'(bus.result_valid), 1);
         chk("hold_status", int'(bus.status), 1);
         chk("hold_cycles", int'(bus.cycles), 4);
      end
      drain();

      // No progress: stall after STALL_LIMIT repeats
      bus.cells_solved = 7'd30;
      start_run();
      wait_valid(12);
      chk("stall_status", int'(bus.status), 3);
      chk("stall_cycles", int'(bus.cycles), 5);
      drain();

      // Fail wins over done in the same cycle
      start_run();
      bus.cells_solved = 7'd10; step();
      bus.cells_solved = 7'd20; step();
      bus.cells_solved = 7'd30; bus.solver_fail = 1'b1; bus.solver_done = 1'b1; step();
      bus.solver_fail = 1'b0; bus.solver_done = 1'b0;
      chk("fail_status", int'(bus.status), 2);
      chk("fail_cycles", int'(bus.cycles), 3);
      drain();

      // Steady progress but never done: cycle-budget timeout
      start_run();
      begin
         int c = 1;
         while (!bus.result_valid && c < 20) begin
            bus.cells_solved = 7'(c);
            c++;
            step();
         end
      end
      chk("timeout_valid", int'(bus.result_valid), 1);
      chk("timeout_status", int'(bus.status), 3);
      chk("timeout_cycles", int'(bus.cycles), 8);
      chk("model_timeout_cycles", m_cycles, 8);
      drain();

      // Abort in SOLVE cycle 2: back to idle without a result
      start_run();
      bus.cells_solved = 7'd5; step();
      bus.abort = 1'b1; step();
      bus.abort = 1'b0;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_status", int'(bus.status), 0);
      repeat (5) begin
         step();
         chk("abort_no_valid", int'(bus.result_valid), 0);
      end

      // Reset mid-solve drops busy immediately; a new run starts cleanly
      start_run();
      bus.cells_solved = 7'd7; step();
      bus.cells_solved = 7'd9;
      #2 reset_L = 1'b0;
      #1;
      chk("async_rst_busy", int'(bus.busy), 0);
      chk("async_rst_cycles", int'(bus.cycles), 0);
      step();
      step();
      reset_L = 1'b1;
      step();
      start_run();
      bus.cells_solved = 7'd11; step();
      bus.solver_done = 1'b1; step();
      bus.solver_done = 1'b0;
      chk("restart_status", int'(bus.status), 1);
      chk("restart_cycles", int'(bus.cycles), 2);
      drain();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bus.load_done    = ($urandom_range(0, 3) == 0);
         bus.abort        = ($urandom_range(0, 19) == 0);
         bus.solver_fail  = ($urandom_range(0, 24) == 0);
         bus.solver_done  = ($urandom_range(0, 14) == 0);
         if ($urandom_range(0, 1) == 1) bus.cells_solved = 7'($urandom_range(0, 81));
         bus.result_ready = ($urandom_range(0, 2) == 0);
         step();
      end

      bus.load_done    = 1'b0;
      bus.abort        = 1'b0;
      bus.solver_fail  = 1'b0;
      bus.solver_done  = 1'b0;
      bus.result_ready = 1'b1;
      repeat (2) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
